// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe -- pipelined immediate generator for the decode stage.
//
// Decodes the base immediate formats (I, S, B, U, J, including the OP-IMM /
// OP-IMM-32 shift-amount forms) from a 32-bit instruction word. Each result is
// sign-extended (shift amounts zero-extended) to XLEN and pushed into a
// 2-entry skid buffer with valid/ready handshakes on both sides.
//
// Optional feature, macro IMM_GEN_TARGET_EN: adds in_pc / out_target. For
// B, J and AUIPC the buffer also stores in_pc + imm (mod 2^XLEN); for all
// other formats out_target is 0. Without the macro, no adder or target
// storage exists.
//
// Ports:
//   clk, rst              core clock, synchronous active-high reset
//   in_valid / in_ready   upstream handshake; in_ready depends on state only
//   in_instr [31:0]       instruction word
//   in_pc [XLEN-1:0]      PC of in_instr (IMM_GEN_TARGET_EN only)
//   out_valid / out_ready downstream handshake on the buffer head
//   out_imm [XLEN-1:0]    extended immediate of the head entry
//   out_fmt [2:0]         0=NONE 1=I 2=S 3=B 4=U 5=J
//   out_illegal           opcode has no immediate format
//   out_target [XLEN-1:0] PC-relative target (IMM_GEN_TARGET_EN only)
// All data outputs read 0 whenever out_valid is 0 (including during rst).

module imm_gen_pipe #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
`ifdef IMM_GEN_TARGET_EN
  input  logic [XLEN-1:0] in_pc,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
`ifdef IMM_GEN_TARGET_EN
  ,
  output logic [XLEN-1:0] out_target
`endif
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OPIMM32  = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;

  // Reduce a 64-bit extended immediate to the datapath width.
  function automatic logic signed [XLEN-1:0] fit_xlen(input logic signed [63:0] v);
    return v[XLEN-1:0];
  endfunction

  // ---- stage p0: combinational format decode of the incoming word ----
  logic [6:0]         opc_p0;
  logic [2:0]         f3_p0;
  logic               is_shift_p0;
  logic signed [63:0] i64_p0, s64_p0, b64_p0, u64_p0, j64_p0, shamt64_p0, shamt32_p0;
  logic signed [63:0] imm64_p0;
  logic signed [XLEN-1:0] imm_p0;
  logic [2:0]         fmt_p0;
  logic               ill_p0;
  logic               vld_p0;

  assign opc_p0      = in_instr[6:0];
  assign f3_p0       = in_instr[14:12];
  assign is_shift_p0 = (f3_p0 == 3'b001) || (f3_p0 == 3'b101);

  assign i64_p0 = {{52{in_instr[31]}}, in_instr[31:20]};
  assign s64_p0 = {{52{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign b64_p0 = {{51{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
  assign u64_p0 = {{32{in_instr[31]}}, in_instr[31:12], 12'b0};
  assign j64_p0 = {{43{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};
  // RV64 OP-IMM shifts carry a 6-bit shamt; RV32 and OP-IMM-32 use 5 bits.
  assign shamt64_p0 = (XLEN == 64) ? {58'b0, in_instr[25:20]} : {59'b0, in_instr[24:20]};
  assign shamt32_p0 = {59'b0, in_instr[24:20]};

  always_comb begin
    fmt_p0   = FMT_NONE;
    ill_p0   = 1'b1;
    imm64_p0 = '0;
    case (opc_p0)
      OPC_LOAD, OPC_JALR: begin
        fmt_p0   = FMT_I;
        ill_p0   = 1'b0;
        imm64_p0 = i64_p0;
      end
      OPC_OPIMM: begin
        fmt_p0   = FMT_I;
        ill_p0   = 1'b0;
        imm64_p0 = is_shift_p0 ? shamt64_p0 : i64_p0;
      end
      OPC_OPIMM32: begin
        // Only an RV64 opcode; stays NONE/illegal on RV32.
        if (XLEN == 64) begin
          fmt_p0   = FMT_I;
          ill_p0   = 1'b0;
          imm64_p0 = is_shift_p0 ? shamt32_p0 : i64_p0;
        end
      end
      OPC_STORE: begin
        fmt_p0   = FMT_S;
        ill_p0   = 1'b0;
        imm64_p0 = s64_p0;
      end
      OPC_BRANCH: begin
        fmt_p0   = FMT_B;
        ill_p0   = 1'b0;
        imm64_p0 = b64_p0;
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt_p0   = FMT_U;
        ill_p0   = 1'b0;
        imm64_p0 = u64_p0;
      end
      OPC_JAL: begin
        fmt_p0   = FMT_J;
        ill_p0   = 1'b0;
        imm64_p0 = j64_p0;
      end
      default: ;
    endcase
  end

  assign imm_p0 = fit_xlen(imm64_p0);

`ifdef IMM_GEN_TARGET_EN
  logic              is_rel_p0;
  logic [XLEN-1:0]   tgt_p0;
  assign is_rel_p0 = (fmt_p0 == FMT_B) || (fmt_p0 == FMT_J) || (opc_p0 == OPC_AUIPC);
  assign tgt_p0    = is_rel_p0 ? (in_pc + imm_p0) : '0;
`endif

  // ---- stage p1: 2-entry skid buffer ----
  logic [1:0]             count_p1;
  logic                   wr_ptr_p1, rd_ptr_p1;
  logic signed [XLEN-1:0] imm_p1 [2];
  logic [2:0]             fmt_p1 [2];
  logic                   ill_p1 [2];
`ifdef IMM_GEN_TARGET_EN
  logic [XLEN-1:0]        tgt_p1 [2];
`endif
  logic                   vld_p1;
  logic                   pop_p1;

  // in_ready is from registered state and rst only, never from out_ready.
  assign in_ready = !rst && (count_p1 != 2'd2);
  assign vld_p0   = in_valid && in_ready;
  assign vld_p1   = !rst && (count_p1 != 2'd0);
  assign pop_p1   = vld_p1 && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_p1  <= 2'd0;
      wr_ptr_p1 <= 1'b0;
      rd_ptr_p1 <= 1'b0;
    end else begin
      if (vld_p0) wr_ptr_p1 <= ~wr_ptr_p1;
      if (pop_p1) rd_ptr_p1 <= ~rd_ptr_p1;
      case ({vld_p0, pop_p1})
        2'b10:   count_p1 <= count_p1 + 2'd1;
        2'b01:   count_p1 <= count_p1 - 2'd1;
        default: count_p1 <= count_p1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p0) begin
      imm_p1[wr_ptr_p1] <= imm_p0;
      fmt_p1[wr_ptr_p1] <= fmt_p0;
      ill_p1[wr_ptr_p1] <= ill_p0;
`ifdef IMM_GEN_TARGET_EN
      tgt_p1[wr_ptr_p1] <= tgt_p0;
`endif
    end
  end

  // Data entries are not reset; the outputs are zeroed whenever the head is invalid.
  assign out_valid   = vld_p1;
  assign out_imm     = vld_p1 ? imm_p1[rd_ptr_p1] : '0;
  assign out_fmt     = vld_p1 ? fmt_p1[rd_ptr_p1] : FMT_NONE;
  assign out_illegal = vld_p1 ? ill_p1[rd_ptr_p1] : 1'b0;
`ifdef IMM_GEN_TARGET_EN
  assign out_target  = vld_p1 ? tgt_p1[rd_ptr_p1] : '0;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: an RV64 and an RV32 instance share the same
// stimulus; a queue-based reference model decodes each accepted word from the
// ISA field definitions and a negedge process compares both DUTs against it.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [63:0] pc;
  logic        out_ready;

  logic        in_ready64, out_valid64, out_ill64;
  logic [63:0] out_imm64, out_tgt64;
  logic [2:0]  out_fmt64;
  logic        in_ready32, out_valid32, out_ill32;
  logic [31:0] out_imm32, out_tgt32;
  logic [2:0]  out_fmt32;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [63:0] tgt;
  } ent_t;

  ent_t q64[$];
  ent_t q32[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr),
`ifdef IMM_GEN_TARGET_EN
    .in_pc(pc),
`endif
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_fmt(out_fmt64), .out_illegal(out_ill64)
`ifdef IMM_GEN_TARGET_EN
    , .out_target(out_tgt64)
`endif
  );

  imm_gen_pipe #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr),
`ifdef IMM_GEN_TARGET_EN
    .in_pc(pc[31:0]),
`endif
    .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
    .out_fmt(out_fmt32), .out_illegal(out_ill32)
`ifdef IMM_GEN_TARGET_EN
    , .out_target(out_tgt32)
`endif
  );

`ifndef IMM_GEN_TARGET_EN
  assign out_tgt64 = '0;
  assign out_tgt32 = '0;
`endif

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference decode straight from the ISA immediate definitions.
  function automatic ent_t mdl(input logic [31:0] ins, input logic [63:0] p, input int xl);
    ent_t e;
    longint v;
    logic [6:0] op;
    logic [2:0] f3;
    bit shift;
    op = ins[6:0];
    f3 = ins[14:12];
    shift = (f3 == 3'd1) || (f3 == 3'd5);
    e.fmt = 3'd0;
    e.ill = 1'b1;
    v = 0;
    case (op)
      7'h03, 7'h67: begin e.fmt = 3'd1; v = longint'($signed(ins[31:20])); end
      7'h13: begin
        e.fmt = 3'd1;
        if (shift) v = (xl == 64) ? longint'({58'b0, ins[25:20]}) : longint'({59'b0, ins[24:20]});
        else       v = longint'($signed(ins[31:20]));
      end
      7'h1B: if (xl == 64) begin
        e.fmt = 3'd1;
        if (shift) v = longint'({59'b0, ins[24:20]});
        else       v = longint'($signed(ins[31:20]));
      end
      7'h23: begin e.fmt = 3'd2; v = longint'($signed({ins[31:25], ins[11:7]})); end
      7'h63: begin e.fmt = 3'd3;
        v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0})); end
      7'h37, 7'h17: begin e.fmt = 3'd4; v = longint'($signed(ins[31:12])) * 4096; end
      7'h6F: begin e.fmt = 3'd5;
        v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0})); end
      default: ;
    endcase
    if (e.fmt != 3'd0) e.ill = 1'b0;
    e.imm = v;
    e.tgt = (e.fmt == 3'd3 || e.fmt == 3'd5 || op == 7'h17) ? p + v : 64'd0;
    if (xl == 32) begin
      e.imm = {32'b0, e.imm[31:0]};
      e.tgt = {32'b0, e.tgt[31:0]};
    end
    return e;
  endfunction

  // Model state update on each clock edge.
  always @(posedge clk) begin : model
    bit rdy, pop;
    if (rst) begin
      q64.delete();
      q32.delete();
    end else begin
      rdy = q64.size() < 2;
      pop = (q64.size() != 0) && out_ready;
      if (pop) begin
        q64.delete(0);
        q32.delete(0);
      end
      if (in_valid && rdy) begin
        q64.push_back(mdl(in_instr, pc, 64));
        q32.push_back(mdl(in_instr, pc, 32));
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin : compare
    logic exp_rdy;
    exp_rdy = !rst && (q64.size() < 2);
    chk("in_ready64", {63'b0, in_ready64}, {63'b0, exp_rdy});
    chk("in_ready32", {63'b0, in_ready32}, {63'b0, exp_rdy});
    if (rst) begin
      chk("rst_valid64", {63'b0, out_valid64}, 64'd0);
      chk("rst_imm64", out_imm64, 64'd0);
      chk("rst_fmt64", {61'b0, out_fmt64}, 64'd0);
      chk("rst_ill64", {63'b0, out_ill64}, 64'd0);
      chk("rst_tgt64", out_tgt64, 64'd0);
      chk("rst_valid32", {63'b0, out_valid32}, 64'd0);
      chk("rst_imm32", {32'b0, out_imm32}, 64'd0);
    end else begin
      chk("valid64", {63'b0, out_valid64}, {63'b0, q64.size() != 0});
      chk("valid32", {63'b0, out_valid32}, {63'b0, q32.size() != 0});
      if (q64.size() != 0) begin
        chk("imm64", out_imm64, q64[0].imm);
        chk("fmt64", {61'b0, out_fmt64}, {61'b0, q64[0].fmt});
        chk("ill64", {63'b0, out_ill64}, {63'b0, q64[0].ill});
        chk("imm32", {32'b0, out_imm32}, q32[0].imm);
        chk("fmt32", {61'b0, out_fmt32}, {61'b0, q32[0].fmt});
        chk("ill32", {63'b0, out_ill32}, {63'b0, q32[0].ill});
`ifdef IMM_GEN_TARGET_EN
        chk("tgt64", out_tgt64, q64[0].tgt);
        chk("tgt32", {32'b0, out_tgt32}, q32[0].tgt);
`endif
      end
    end
  end

  // Present a word until the DUT accepts it; called just after a posedge.
  task automatic push(input logic [31:0] ins, input logic [63:0] p);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    in_instr = ins;
    pc = p;
    do begin
      @(negedge clk);
      acc = in_ready64;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    chk("push_accept_timeout", {63'b0, acc}, 64'd1);
    in_valid = 1'b0;
  endtask

  logic [31:0] vec [10];
  ent_t e;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_instr = '0;
    pc = '0;
    out_ready = 1'b1;

    // Pin the model with hand-computed values.
    e = mdl(32'hFF813083, 64'd0, 64);
    chk("mdl_ld_imm", e.imm, 64'hFFFFFFFFFFFFFFF8);
    e = mdl(32'hFE000EE3, 64'h1000, 64);
    chk("mdl_beq_tgt", e.tgt, 64'h0FFC);
    e = mdl(32'h800002B7, 64'd0, 32);
    chk("mdl_lui32", e.imm, 64'h80000000);
    e = mdl(32'h4030D093, 64'd0, 64);
    chk("mdl_srai", e.imm, 64'd3);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    push(32'hFF813083, 64'h2000);
    @(negedge clk);
    chk("ld_valid", {63'b0, out_valid64}, 64'd1);
    chk("ld_imm", out_imm64, 64'hFFFFFFFFFFFFFFF8);
    chk("ld_fmt", {61'b0, out_fmt64}, 64'd1);
    chk("ld_ill", {63'b0, out_ill64}, 64'd0);
    @(posedge clk); #1;

    push(32'hFE000EE3, 64'h1000);
    @(negedge clk);
    chk("beq_imm", out_imm64, 64'hFFFFFFFFFFFFFFFC);
    chk("beq_fmt", {61'b0, out_fmt64}, 64'd3);
`ifdef IMM_GEN_TARGET_EN
    chk("beq_tgt", out_tgt64, 64'h0FFC);
`endif
    @(posedge clk); #1;

    push(32'h03F09093, 64'h0);
    @(negedge clk);
    chk("slli_imm", out_imm64, 64'h3F);
    chk("slli_fmt", {61'b0, out_fmt64}, 64'd1);
    @(posedge clk); #1;

    push(32'h800002B7, 64'h0);
    @(negedge clk);
    chk("lui_imm64", out_imm64, 64'hFFFFFFFF80000000);
    chk("lui_fmt", {61'b0, out_fmt64}, 64'd4);
    chk("lui_imm32", {32'b0, out_imm32}, 64'h80000000);
    @(posedge clk); #1;

    push(32'h0000007F, 64'h0);
    @(negedge clk);
    chk("illeg_fmt", {61'b0, out_fmt64}, 64'd0);
    chk("illeg_imm", out_imm64, 64'd0);
    chk("illeg_ill", {63'b0, out_ill64}, 64'd1);
    @(posedge clk); #1;

    push(32'h0000009B, 64'h0);
    @(negedge clk);
    chk("opimm32_ill32", {63'b0, out_ill32}, 64'd1);
    chk("opimm32_ill64", {63'b0, out_ill64}, 64'd0);
    @(posedge clk); #1;

    // Mixed formats back-to-back with intermittent backpressure.
    vec[0] = 32'h00112623;  // sw x1,12(x2)
    vec[1] = 32'h4030D093;  // srai x1,x1,3
    vec[2] = 32'h02109093;  // slli with instr[25] set
    vec[3] = 32'h0210909B;  // slliw with instr[25] set
    vec[4] = 32'h12345517;  // auipc x10,0x12345
    vec[5] = 32'hFFDFF0EF;  // jal x1,-4
    vec[6] = 32'h00008067;  // jalr x0,0(x1)
    vec[7] = 32'h0000000F;  // fence: no immediate format
    vec[8] = 32'h80000863;  // beq, large negative offset
    vec[9] = 32'h8000006F;  // jal, most negative offset
    for (int i = 0; i < 10; i++) begin
      out_ready = (i % 3) != 2;
      push(vec[i], 64'h8000_0000_0000_1000 + 64'(i * 4));
    end
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: A and B fill the buffer, C must wait.
    out_ready = 1'b0;
    push(32'h00100093, 64'h0);   // A: addi x1,x0,1
    push(32'h00112623, 64'h0);   // B: sw x1,12(x2)
    in_valid = 1'b1;
    in_instr = 32'h008000EF;     // C: jal x1,8
    @(negedge clk);
    chk("bp_ready_low", {63'b0, in_ready64}, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("bp_head_held", out_imm64, 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    push(32'h008000EF, 64'h0);
    repeat (4) @(posedge clk);
    #1;

    // Reset with two entries buffered.
    out_ready = 1'b0;
    push(32'h00100093, 64'h0);
    push(32'h00112623, 64'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", {63'b0, out_valid64}, 64'd0);
    chk("mid_rst_ready", {63'b0, in_ready64}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {63'b0, in_ready64}, 64'd1);
    chk("post_rst_valid", {63'b0, out_valid64}, 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    push(32'h00000517, 64'h40);
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
